// File: rtl/pwm_pkg.sv
// Shared definitions for the servo PWM receive path:
// decoder FSM states, nominal 50 MHz widths and position codes.
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } state_t;

    localparam int CLK_HZ_NOM     = 50_000_000;
    localparam int CNT_W_NOM      = 21;
    localparam int W_MIN_NOM      = 45_000;
    localparam int TH1_NOM        = 58_333;
    localparam int TH2_NOM        = 75_000;
    localparam int TH3_NOM        = 91_667;
    localparam int W_MAX_NOM      = 105_000;
    localparam int PERIOD_MAX_NOM = 1_100_000;

    localparam logic [1:0] POS_0 = 2'b00;
    localparam logic [1:0] POS_1 = 2'b01;
    localparam logic [1:0] POS_2 = 2'b10;
    localparam logic [1:0] POS_3 = 2'b11;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for an asynchronous level input,
// with registered one-cycle rise and fall strobes.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pwm,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    // Preset high so a line already high at reset release
    // cannot produce a rise until it has been seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            dly  <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= pwm;
            sync <= meta;
            dly  <= sync;
            rise <= sync & ~dly;
            fall <= ~sync & dly;
        end
    end

    assign level = sync;

endmodule

// File: rtl/pwm_decoder.sv
// Servo PWM receiver: measures pulse high time, decodes the
// 2-bit position, flags illegal widths and loss of signal.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W      = CNT_W_NOM,
    parameter int W_MIN      = W_MIN_NOM,
    parameter int TH1        = TH1_NOM,
    parameter int TH2        = TH2_NOM,
    parameter int TH3        = TH3_NOM,
    parameter int W_MAX      = W_MAX_NOM,
    parameter int PERIOD_MAX = PERIOD_MAX_NOM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [1:0] pos,
    output logic       valid,
    output logic       err,
    output logic       lost
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] W_MIN_C = CNT_W'(W_MIN);
    localparam logic [CNT_W-1:0] TH1_C   = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] TH2_C   = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] TH3_C   = CNT_W'(TH3);
    localparam logic [CNT_W-1:0] W_MAX_C = CNT_W'(W_MAX);
    localparam logic [CNT_W-1:0] PER_C   = CNT_W'(PERIOD_MAX);

    if (!(W_MIN < TH1 && TH1 < TH2 && TH2 < TH3 && TH3 < W_MAX &&
          W_MAX < PERIOD_MAX && PERIOD_MAX < (1 << CNT_W)))
    begin : g_param_check
        $error("pwm_decoder: thresholds out of order or too wide");
    end

    logic             level;
    logic             rise;
    logic             fall;
    state_t           state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             legal;
    logic [1:0]       code;

    pwm_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Width classification of the pulse currently being measured.
    always_comb begin
        legal = (hi_cnt >= W_MIN_C) && (hi_cnt <= W_MAX_C);
        code  = POS_3;
        if (hi_cnt < TH1_C) begin
            code = POS_0;
        end else if (hi_cnt < TH2_C) begin
            code = POS_1;
        end else if (hi_cnt < TH3_C) begin
            code = POS_2;
        end
    end

    // Measurement FSM, period watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOW;
            hi_cnt  <= '0;
            per_cnt <= '0;
            pos     <= POS_0;
            valid   <= 1'b0;
            err     <= 1'b0;
            lost    <= 1'b1;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;

            if (rise) begin
                per_cnt <= CNT_ONE;
            end else begin
                if (per_cnt != CNT_MAX) begin
                    per_cnt <= per_cnt + CNT_ONE;
                end
                if (per_cnt >= PER_C) begin
                    lost <= 1'b1;
                end
            end

            unique case (state)
                WAIT_LOW: begin
                    if (!level) begin
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state  <= HIGH;
                        hi_cnt <= CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= WAIT_RISE;
                        if (legal) begin
                            valid <= 1'b1;
                            pos   <= code;
                            lost  <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (hi_cnt != CNT_MAX) begin
                        hi_cnt <= hi_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= WAIT_LOW;
                end
            endcase
        end
    end

endmodule
